fir_stream_source: RTL and testbench
====================================

Name: fir_stream_source

Overview:
Synthesizable transmit side of the FIR filter's sample interface.
- Buffers host-written 12-bit samples in a FIFO and streams them onto DIN/VIN with a programmable idle gap between valid samples.
- Holds the 9-tap coefficient bank and drives it on B0..B8.
- Sits in front of the FIR filter. Used both as an on-chip stimulus source and as the front end of the test harness.

Parameters:
- DW, 12, sample and coefficient width (two's complement)
- DEPTH, 16, FIFO depth in samples (power of 2)
- AW, 4, FIFO address width, log2(DEPTH)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_n  in  1  asynchronous active-low reset
- WR_EN  in  1  push WR_DATA into FIFO
- WR_DATA  in  DW  sample to push
- FULL  out  1  FIFO holds DEPTH samples
- EMPTY  out  1  FIFO holds 0 samples
- COEF_WE  in  1  write coefficient register
- COEF_ADDR  in  4  coefficient index 0..8
- COEF_DATA  in  DW  coefficient value
- START  in  1  begin streaming (pulse)
- STOP  in  1  end streaming (pulse)
- GAP_LEN  in  4  idle cycles inserted after each valid sample
- DIN  out  DW  sample to filter
- VIN  out  1  DIN valid, one cycle per sample
- B0..B8  out  DW each  coefficient registers 0..8
- BUSY  out  1  FSM not in IDLE
- DONE  out  1  one-cycle pulse on return to IDLE
- UFLOW_CNT  out  8  underflow counter (see Optional Feature)

Behaviour:
- Reset values: DIN=0, VIN=0, B0..B8=0, FULL=0, EMPTY=1, BUSY=0, DONE=0, UFLOW_CNT=0. FIFO pointers and count are cleared. FSM goes to IDLE.
- Reset asserted mid-stream aborts immediately. FIFO contents are discarded.
- FIFO:
  - Count 0..DEPTH; pointers wrap modulo DEPTH.
  - Push is accepted iff WR_EN=1 and count<DEPTH; a push when full is dropped silently.
  - Pop is internal only: it occurs iff FSM is in SEND and count>0.
  - Push and pop in the same cycle: count is unchanged. This is legal at full, because the pop frees a slot.
  - Push to an empty FIFO is not visible to the pop until the next cycle.
  - FULL and EMPTY are derived from the registered count.
- Coefficients:
  - Written only when the FSM is in IDLE and COEF_ADDR<=8; the register updates on the next edge.
  - Writes while BUSY, or with COEF_ADDR>8, are ignored.
  - B0..B8 are therefore constant throughout a stream.
- FSM states: IDLE, SEND, GAP.
  - IDLE: VIN=0. START moves to SEND; GAP_LEN is sampled into gap_reg on that edge. STOP is ignored in IDLE.
  - SEND, FIFO non-empty: pop the sample. Next cycle DIN=sample and VIN=1 (latency 1 from pop). Then go to GAP if gap_reg>0, otherwise stay in SEND, giving back-to-back samples at VIN=1 every cycle.
  - SEND, FIFO empty: VIN=0 and DIN holds its last value. This is an underflow cycle; stay in SEND.
  - GAP: VIN=0, DIN held. A 4-bit counter counts gap_reg cycles, then returns to SEND.
  - START while BUSY is ignored.
- STOP while BUSY:
  - A sample already popped is still presented with VIN=1.
  - The FSM then enters IDLE instead of SEND/GAP, and DONE pulses for one cycle on entry to IDLE.
  - STOP and a pop in the same cycle: the pop completes and that sample is the last one sent.
  - Unsent FIFO samples are retained.
- DIN changes only in the cycle VIN rises. It is never changed while VIN=0.

Optional Feature:
- Macro: SRC_UFLOW_CNT_EN.
- Defined: UFLOW_CNT is an 8-bit saturating counter (stops at 255). It increments on each SEND cycle with an empty FIFO and is cleared on START accepted and on reset.
- Undefined: UFLOW_CNT is tied to 0 and no counter logic is present.

Test Plan:
- Reset, write COEF_ADDR 0..8 = 1..9, pulse START → B0..B8 = 1..9; COEF_WE at addr 4 = 77 while BUSY → B4 stays 5; COEF_ADDR=12 in IDLE → no change.
- Push 3 samples 100,-200,300, GAP_LEN=0, START → VIN high 3 consecutive cycles, DIN 100,-200,300, first VIN one cycle after SEND entry; then VIN=0 and EMPTY=1.
- GAP_LEN=2, push 5,6 → VIN pattern 1,0,0,1; DIN holds 5 during the gap.
- Push 17 samples with no START → FULL=1 after 16, the 17th is dropped; stream out → exactly 16 samples, in order.
- STOP after the 2nd VIN with 4 samples queued → 2 (or 3 if a pop coincides) samples sent, DONE one pulse, EMPTY=0, BUSY=0.
- With SRC_UFLOW_CNT_EN, START on an empty FIFO for 300 cycles → UFLOW_CNT=255; RST_n low for one cycle mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fir_stream_source.sv
// Transmit side of the FIR sample interface: sample FIFO, paced streamer and 9-tap coefficient bank.
// Optional underflow counter enabled by defining SRC_UFLOW_CNT_EN.
module fir_stream_source #(
  parameter int DW    = 12,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          WR_EN,
  input  logic [DW-1:0] WR_DATA,
  output logic          FULL,
  output logic          EMPTY,
  input  logic          COEF_WE,
  input  logic [3:0]    COEF_ADDR,
  input  logic [DW-1:0] COEF_DATA,
  input  logic          START,
  input  logic          STOP,
  input  logic [3:0]    GAP_LEN,
  output logic [DW-1:0] DIN,
  output logic          VIN,
  output logic [DW-1:0] B0,
  output logic [DW-1:0] B1,
  output logic [DW-1:0] B2,
  output logic [DW-1:0] B3,
  output logic [DW-1:0] B4,
  output logic [DW-1:0] B5,
  output logic [DW-1:0] B6,
  output logic [DW-1:0] B7,
  output logic [DW-1:0] B8,
  output logic          BUSY,
  output logic          DONE,
  output logic [7:0]    UFLOW_CNT
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  state_t        state_q, state_d;
  logic [AW:0]   count_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] din_q;
  logic          vin_q, done_q;
  logic [3:0]    gap_reg_q, gap_cnt_q;
  logic [DW-1:0] coef_q [9];

  logic push, pop, start_accept, coef_write;

  assign pop          = (state_q == SEND) && (count_q != '0);
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign push         = WR_EN && ((count_q != FULL_COUNT) || pop);
  assign start_accept = (state_q == IDLE) && START;
  assign coef_write   = (state_q == IDLE) && COEF_WE && (COEF_ADDR <= 4'd8);

  // NOTE: sample storage has no reset; pointers and count alone define validity.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= WR_DATA;
  end

  // NOTE: all state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: next-state defaults to the current state first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (START) state_d = SEND;
      SEND: begin
        if (STOP)                          state_d = IDLE;
        else if (pop && gap_reg_q != '0)   state_d = GAP;
      end
      GAP: begin
        if (STOP)                                state_d = IDLE;
        else if (gap_cnt_q == gap_reg_q - 4'd1)  state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      gap_reg_q <= '0;
      gap_cnt_q <= '0;
      din_q     <= '0;
      vin_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_accept) gap_reg_q <= GAP_LEN;
      gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + 4'd1 : 4'd0;
      // DIN only moves together with a rising/held VIN, never during idle cycles.
      vin_q <= pop;
      if (pop) din_q <= mem[rd_ptr_q];
      done_q <= (state_q != IDLE) && (state_d == IDLE);
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 9; i++) coef_q[i] <= '0;
    end else if (coef_write) begin
      coef_q[COEF_ADDR] <= COEF_DATA;
    end
  end

`ifdef SRC_UFLOW_CNT_EN
  logic [7:0] uflow_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      uflow_q <= '0;
    end else if (start_accept) begin
      uflow_q <= '0;
    end else if ((state_q == SEND) && (count_q == '0) && (uflow_q != 8'hFF)) begin
      uflow_q <= uflow_q + 8'd1;
    end
  end

  assign UFLOW_CNT = uflow_q;
`else
  assign UFLOW_CNT = '0;
`endif

  assign FULL  = (count_q == FULL_COUNT);
  assign EMPTY = (count_q == '0);
  assign BUSY  = (state_q != IDLE);
  assign DONE  = done_q;
  assign DIN   = din_q;
  assign VIN   = vin_q;
  assign B0    = coef_q[0];
  assign B1    = coef_q[1];
  assign B2    = coef_q[2];
  assign B3    = coef_q[3];
  assign B4    = coef_q[4];
  assign B5    = coef_q[5];
  assign B6    = coef_q[6];
  assign B7    = coef_q[7];
  assign B8    = coef_q[8];

endmodule

// File: tb/tb_fir_stream_source.sv
// Directed bench for fir_stream_source: queue scoreboard on the DIN/VIN stream plus
// step-by-step checks of coefficients, pacing, STOP/DONE, FULL and reset.
module tb_fir_stream_source;

  localparam int DW = 12;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic          WR_EN;
  logic [DW-1:0] WR_DATA;
  logic          FULL, EMPTY;
  logic          COEF_WE;
  logic [3:0]    COEF_ADDR;
  logic [DW-1:0] COEF_DATA;
  logic          START, STOP;
  logic [3:0]    GAP_LEN;
  logic [DW-1:0] DIN;
  logic          VIN;
  logic [DW-1:0] B0, B1, B2, B3, B4, B5, B6, B7, B8;
  logic          BUSY, DONE;
  logic [7:0]    UFLOW_CNT;

  logic [DW-1:0] b_obs [9];
  logic [DW-1:0] sb [$];
  int checks   = 0;
  int failures = 0;
  int vin_count = 0;
  int model_count;
  logic [DW-1:0] v;
  logic [7:0] uflow_exp;

  fir_stream_source dut (
    .CLK(CLK), .RST_n(RST_n), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
    .FULL(FULL), .EMPTY(EMPTY), .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR),
    .COEF_DATA(COEF_DATA), .START(START), .STOP(STOP), .GAP_LEN(GAP_LEN),
    .DIN(DIN), .VIN(VIN), .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4),
    .B5(B5), .B6(B6), .B7(B7), .B8(B8), .BUSY(BUSY), .DONE(DONE),
    .UFLOW_CNT(UFLOW_CNT)
  );

  assign b_obs[0] = B0; assign b_obs[1] = B1; assign b_obs[2] = B2;
  assign b_obs[3] = B3; assign b_obs[4] = B4; assign b_obs[5] = B5;
  assign b_obs[6] = B6; assign b_obs[7] = B7; assign b_obs[8] = B8;

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_sample(input logic [DW-1:0] d);
    WR_EN   = 1'b1;
    WR_DATA = d;
    if (model_count < 16) begin
      sb.push_back(d);
      model_count++;
    end
    tick();
    WR_EN = 1'b0;
  endtask

  // Every valid output sample must be the oldest outstanding pushed sample.
  always @(negedge CLK) begin
    if (RST_n && VIN) begin
      vin_count++;
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("din_order", 32'(DIN), 32'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_n = 1'b0; WR_EN = 1'b0; WR_DATA = '0; COEF_WE = 1'b0; COEF_ADDR = '0;
    COEF_DATA = '0; START = 1'b0; STOP = 1'b0; GAP_LEN = '0; model_count = 0;
    #12;
    check("rst_vin",   32'(VIN), 32'd0);
    check("rst_din",   32'(DIN), 32'd0);
    check("rst_empty", 32'(EMPTY), 32'd1);
    check("rst_full",  32'(FULL), 32'd0);
    check("rst_busy",  32'(BUSY), 32'd0);
    check("rst_done",  32'(DONE), 32'd0);
    check("rst_uflow", 32'(UFLOW_CNT), 32'd0);
    check("rst_b8",    32'(B8), 32'd0);
    @(posedge CLK); #1;
    RST_n = 1'b1;

    // Coefficient bank: load 1..9, then an out-of-range address must be ignored.
    for (int i = 0; i < 9; i++) begin
      COEF_WE = 1'b1; COEF_ADDR = 4'(i); COEF_DATA = 12'(i + 1);
      tick();
    end
    COEF_ADDR = 4'd12; COEF_DATA = 12'd99;
    tick();
    COEF_WE = 1'b0;
    for (int i = 0; i < 9; i++) check("coef_load", 32'(b_obs[i]), 32'(i + 1));
    START = 1'b1; tick(); START = 1'b0;
    check("busy_after_start", 32'(BUSY), 32'd1);
    COEF_WE = 1'b1; COEF_ADDR = 4'd4; COEF_DATA = 12'd77;
    tick();
    COEF_WE = 1'b0;
    check("coef_locked_busy", 32'(B4), 32'd5);
    STOP = 1'b1; tick(); STOP = 1'b0;
    check("stop_done", 32'(DONE), 32'd1);
    check("stop_busy", 32'(BUSY), 32'd0);
    tick();
    check("done_one_cycle", 32'(DONE), 32'd0);

    // Back-to-back stream with no gap.
    GAP_LEN = 4'd0;
    push_sample(12'd100);
    push_sample(12'(-200));
    push_sample(12'd300);
    START = 1'b1; tick(); START = 1'b0;
    check("b2b_send_entry_vin", 32'(VIN), 32'd0);
    tick(); check("b2b_vin0", 32'(VIN), 32'd1);
    tick(); check("b2b_vin1", 32'(VIN), 32'd1);
    tick(); check("b2b_vin2", 32'(VIN), 32'd1);
    tick();
    check("b2b_vin_end", 32'(VIN), 32'd0);
    check("b2b_empty", 32'(EMPTY), 32'd1);
    check("b2b_din_hold", 32'(DIN), 32'd300);
    STOP = 1'b1; tick(); STOP = 1'b0;
    check("b2b_done", 32'(DONE), 32'd1);
    tick();

    // Two idle cycles between samples; DIN held across the gap.
    GAP_LEN = 4'd2;
    push_sample(12'd5);
    push_sample(12'd6);
    START = 1'b1; tick(); START = 1'b0;
    tick(); check("gap_vin_a", 32'(VIN), 32'd1); check("gap_din_a", 32'(DIN), 32'd5);
    tick(); check("gap_vin_b", 32'(VIN), 32'd0); check("gap_din_b", 32'(DIN), 32'd5);
    tick(); check("gap_vin_c", 32'(VIN), 32'd0); check("gap_din_c", 32'(DIN), 32'd5);
    tick(); check("gap_vin_d", 32'(VIN), 32'd1); check("gap_din_d", 32'(DIN), 32'd6);
    tick(); check("gap_vin_e", 32'(VIN), 32'd0);
    STOP = 1'b1; tick(); STOP = 1'b0;
    check("gap_stop_done", 32'(DONE), 32'd1);
    tick();

    // Fill beyond capacity: the 17th push is dropped and exactly 16 stream out.
    GAP_LEN = 4'd0;
    model_count = 0;
    for (int i = 0; i < 16; i++) push_sample(12'(i * 7 + 1));
    check("full_at_16", 32'(FULL), 32'd1);
    push_sample(12'd2047);
    check("full_after_drop", 32'(FULL), 32'd1);
    vin_count = 0;
    START = 1'b1; tick(); START = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("full_stream_count", 32'(vin_count), 32'd16);
    check("full_stream_empty", 32'(EMPTY), 32'd1);
    check("full_sb_drained", 32'(sb.size()), 32'd0);
    STOP = 1'b1; tick(); STOP = 1'b0;
    tick();

    // STOP after the second valid sample; the coinciding pop is the last one sent.
    model_count = 0;
    for (int i = 0; i < 4; i++) push_sample(12'(500 + i));
    vin_count = 0;
    START = 1'b1; tick(); START = 1'b0;
    tick();
    tick(); check("stop_mid_vin2", 32'(VIN), 32'd1);
    STOP = 1'b1; tick(); STOP = 1'b0;
    check("stop_mid_last_vin", 32'(VIN), 32'd1);
    check("stop_mid_last_din", 32'(DIN), 32'd502);
    check("stop_mid_done", 32'(DONE), 32'd1);
    check("stop_mid_busy", 32'(BUSY), 32'd0);
    check("stop_mid_empty", 32'(EMPTY), 32'd0);
    tick();
    check("stop_mid_count", 32'(vin_count), 32'd3);
    check("stop_mid_done_clr", 32'(DONE), 32'd0);
    check("stop_mid_vin_off", 32'(VIN), 32'd0);

    // Retained sample drains first, then a long underflow run.
    START = 1'b1; tick(); START = 1'b0;
    for (int i = 0; i < 300; i++) tick();
`ifdef SRC_UFLOW_CNT_EN
    uflow_exp = 8'd255;
`else
    uflow_exp = 8'd0;
`endif
    check("uflow_saturate", 32'(UFLOW_CNT), 32'(uflow_exp));
    check("uflow_sb_drained", 32'(sb.size()), 32'd0);

    // Live stream fed one sample per cycle, then an asynchronous reset mid-cycle.
    model_count = 0;
    for (int i = 0; i < 6; i++) begin
      v = 12'(900 + i);
      WR_EN = 1'b1; WR_DATA = v; sb.push_back(v);
      tick();
    end
    WR_EN = 1'b0;
    check("live_vin", 32'(VIN), 32'd1);
    check("live_din", 32'(DIN), 32'd904);
    #2 RST_n = 1'b0;
    #1;
    sb.delete();
    check("arst_vin",   32'(VIN), 32'd0);
    check("arst_din",   32'(DIN), 32'd0);
    check("arst_busy",  32'(BUSY), 32'd0);
    check("arst_empty", 32'(EMPTY), 32'd1);
    check("arst_uflow", 32'(UFLOW_CNT), 32'd0);
    check("arst_b0",    32'(B0), 32'd0);
    check("arst_b4",    32'(B4), 32'd0);
    @(posedge CLK); #1;
    RST_n = 1'b1;
    tick();
    check("post_rst_busy",  32'(BUSY), 32'd0);
    check("post_rst_empty", 32'(EMPTY), 32'd1);
    check("post_rst_vin",   32'(VIN), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
